// File: rtl/color_shuffler_pkg.sv
// Shared definitions for the memory-game colour shuffler: board geometry,
// colour width and the shuffle FSM state encoding.
package color_shuffler_pkg;

  localparam int NUM_CARDS  = 16;
  localparam int CARD_IDX_W = 4;
  localparam int COLOR_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_SHUFFLE = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // Unshuffled board: card k holds colour k/2, so every colour appears twice.
  function automatic logic [COLOR_W-1:0] init_color(input logic [CARD_IDX_W-1:0] k);
    return k[CARD_IDX_W-1:1];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/color_shuffler.sv
// Builds a 4x4 board of colour pairs and shuffles it with a downward
// Fisher-Yates pass driven by a free-running LFSR (rejection sampling on j).
module color_shuffler
  import color_shuffler_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  compute_colors_en,
  input  logic [CARD_IDX_W-1:0] card_idx,
  output logic                  compute_done,
  output logic [COLOR_W-1:0]    card_color,
  output logic                  colors_valid,
  output state_e                dbg_state,
  output logic [15:0]           dbg_lfsr
);

  state_e                  state_q, state_d;
  logic [CARD_IDX_W-1:0]   idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic [COLOR_W-1:0]      color_q, color_d;
  logic [COLOR_W-1:0]      entry_q [NUM_CARDS];
  logic [COLOR_W-1:0]      entry_d [NUM_CARDS];
  logic [15:0]             lfsr_val;
  logic [CARD_IDX_W-1:0]   j;
  logic                    done;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_val)
  );

  assign j = lfsr_val[CARD_IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    entry_d = entry_q;
    done    = 1'b0;
    color_d = entry_q[card_idx];

    case (state_q)
      ST_IDLE: begin
        if (compute_colors_en) begin
          state_d = ST_INIT;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_INIT: begin
        if (!compute_colors_en) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          entry_d[idx_q] = init_color(idx_q);
          if (idx_q == CARD_IDX_W'(NUM_CARDS - 1)) begin
            state_d = ST_SHUFFLE;
            idx_d   = CARD_IDX_W'(NUM_CARDS - 1);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_SHUFFLE: begin
        if (!compute_colors_en) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (j <= idx_q) begin
          // j == i writes the same value back, which is still a valid step.
          entry_d[idx_q] = entry_q[j];
          entry_d[j]     = entry_q[idx_q];
          if (idx_q == CARD_IDX_W'(1)) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!compute_colors_en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      color_q <= '0;
      for (int k = 0; k < NUM_CARDS; k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      color_q <= color_d;
      for (int k = 0; k < NUM_CARDS; k++) begin
        entry_q[k] <= entry_d[k];
      end
    end
  end

  assign compute_done = done;
  assign card_color   = color_q;
  assign colors_valid = valid_q;
  assign dbg_state    = state_q;
  assign dbg_lfsr     = lfsr_val;

endmodule

// File: tb/tb_color_shuffler.sv
// Bench for color_shuffler: LFSR reference, Fisher-Yates prediction queue,
// table-driven reads and hand-written abort/reset sequences.
module tb_color_shuffler;
  import color_shuffler_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic [CARD_IDX_W-1:0] card_idx = '0;
  logic                  compute_done;
  logic [COLOR_W-1:0]    card_color;
  logic                  colors_valid;
  state_e                dbg_state;
  logic [15:0]           dbg_lfsr;

  always #5 clk = ~clk;

  color_shuffler #(.LFSR_SEED(16'hACE1)) dut (
    .clk               (clk),
    .rst               (rst),
    .compute_colors_en (en),
    .card_idx          (card_idx),
    .compute_done      (compute_done),
    .card_color        (card_color),
    .colors_valid      (colors_valid),
    .dbg_state         (dbg_state),
    .dbg_lfsr          (dbg_lfsr)
  );

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic [79:0] exp_q[$];
  logic [79:0] e;
  logic [47:0] last_board = '0;

  typedef struct {
    logic [3:0] idx;
    logic [2:0] exp;
  } rd_vec_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // l0 = LFSR value in the cycle en is driven high; c0 = that cycle number.
  // Returns {cycle of compute_done, packed final board}.
  function automatic logic [79:0] predict(input logic [15:0] l0, input int c0);
    logic [2:0]  b [16];
    logic [2:0]  tmp;
    logic [15:0] l;
    logic [3:0]  jj;
    logic [47:0] pb;
    int          t;
    int          i;
    l = l0;
    t = c0;
    for (int k = 0; k < 16; k++) b[k] = 3'(k >> 1);
    repeat (17) begin
      l = lfsr_next(l);
      t++;
    end
    i = 15;
    while (i >= 1) begin
      jj = l[3:0];
      if (int'(jj) <= i) begin
        tmp = b[i];
        b[i] = b[jj];
        b[jj] = tmp;
        i--;
      end
      l = lfsr_next(l);
      t++;
    end
    for (int k = 0; k < 16; k++) pb[3*k +: 3] = b[k];
    return {32'(t), pb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: LFSR tracking and compute_done scoreboard.
  always begin
    @(posedge clk);
    cyc++;
    lfsr_m = rst ? 16'hACE1 : lfsr_next(lfsr_m);
    #1;
    check("lfsr_track", dbg_lfsr, lfsr_m);
    if (compute_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e[79:48]));
        last_board = e[47:0];
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic raise_en();
    exp_q.push_back(predict(lfsr_m, cyc));
    en = 1'b1;
  endtask

  task automatic cancel_expect();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt != start) break;
    end
    check("done_seen", 64'(done_cnt - start), 64'(1));
  endtask

  task automatic wait_state(input state_e s, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (dbg_state == s) break;
    end
    check("reach_state", 64'(dbg_state), 64'(s));
  endtask

  task automatic read_board(input logic [47:0] board);
    int hist [8];
    for (int v = 0; v < 8; v++) hist[v] = 0;
    for (int k = 0; k < 16; k++) begin
      card_idx = 4'(k);
      tick();
      check("board_entry", 64'(card_color), 64'(board[3*k +: 3]));
      check("board_valid", 64'(colors_valid), 64'(1));
      hist[card_color]++;
    end
    for (int v = 0; v < 8; v++) check("color_pair", 64'(hist[v]), 64'(2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t     init_tab [10];
    logic [47:0] board1;
    int          raise_cyc;
    int          start;

    // Contents after an abort that lets INIT write entries 0..7 on a cleared board.
    init_tab[0] = '{4'd5, 3'd2};
    init_tab[1] = '{4'd6, 3'd3};
    init_tab[2] = '{4'd7, 3'd3};
    init_tab[3] = '{4'd8, 3'd0};
    init_tab[4] = '{4'd0, 3'd0};
    init_tab[5] = '{4'd3, 3'd1};
    init_tab[6] = '{4'd15, 3'd0};
    init_tab[7] = '{4'd4, 3'd2};
    init_tab[8] = '{4'd1, 3'd0};
    init_tab[9] = '{4'd2, 3'd1};

    // Reset for two cycles.
    tick(2);
    check("rst_done", 64'(compute_done), 64'(0));
    check("rst_valid", 64'(colors_valid), 64'(0));
    check("rst_color", 64'(card_color), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_lfsr", 64'(dbg_lfsr), 64'(16'hACE1));
    rst = 1'b0;
    tick(3);

    // Abort during INIT after 8 writes, then table-driven reads.
    raise_en();
    tick(9);
    en = 1'b0;
    cancel_expect();
    tick();
    check("init_abort_state", 64'(dbg_state), 64'(ST_IDLE));
    for (int k = 0; k < 10; k++) begin
      card_idx = init_tab[k].idx;
      tick();
      check("init_tab_color", 64'(card_color), 64'(init_tab[k].exp));
      check("init_tab_valid", 64'(colors_valid), 64'(0));
    end

    // Full shuffle with en held.
    raise_cyc = cyc;
    raise_en();
    tick();
    check("init_state", 64'(dbg_state), 64'(ST_INIT));
    check("init_valid", 64'(colors_valid), 64'(0));
    wait_done(300);
    check("done_valid", 64'(colors_valid), 64'(1));
    check("latency_ge_31", 64'((last_done_cyc - (raise_cyc + 1)) >= 31), 64'(1));
    start = done_cnt;
    tick(100);
    check("no_second_done", 64'(done_cnt), 64'(start));
    check("hold_state", 64'(dbg_state), 64'(ST_HOLD));
    read_board(last_board);
    board1 = last_board;

    // Re-arm: one low cycle keeps the board; then a new shuffle.
    card_idx = 4'd5;
    en = 1'b0;
    tick();
    check("rearm_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("rearm_keep_valid", 64'(colors_valid), 64'(1));
    check("rearm_keep_entry5", 64'(card_color), 64'(board1[15 +: 3]));
    raise_en();
    wait_done(300);
    check("perm_differs", 64'(last_board != board1), 64'(1));
    read_board(last_board);

    // Abort five cycles into SHUFFLE, then complete normally.
    en = 1'b0;
    tick($urandom_range(2, 8));
    raise_en();
    wait_state(ST_SHUFFLE, 40);
    tick(5);
    en = 1'b0;
    cancel_expect();
    tick();
    check("shuf_abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("shuf_abort_valid", 64'(colors_valid), 64'(0));
    start = done_cnt;
    tick(60);
    check("shuf_abort_no_done", 64'(done_cnt), 64'(start));
    raise_en();
    wait_done(300);
    read_board(last_board);

    // Reset mid-SHUFFLE with en still high.
    en = 1'b0;
    tick($urandom_range(2, 8));
    raise_en();
    wait_state(ST_SHUFFLE, 40);
    tick(3);
    rst = 1'b1;
    cancel_expect();
    tick();
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_done", 64'(compute_done), 64'(0));
    check("mid_rst_valid", 64'(colors_valid), 64'(0));
    check("mid_rst_color", 64'(card_color), 64'(0));
    check("mid_rst_lfsr", 64'(dbg_lfsr), 64'(16'hACE1));
    rst = 1'b0;
    en = 1'b0;
    start = done_cnt;
    tick(60);
    check("mid_rst_no_done", 64'(done_cnt), 64'(start));

    // One more complete shuffle after the reset.
    raise_en();
    wait_done(300);
    read_board(last_board);
    en = 1'b0;
    tick(2);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/color_shuffler.md
COLOR_SHUFFLER -- requirements
Module: color_shuffler

Interface
REQ-001 Parameter: LFSR_SEED, default 16'hACE1, LFSR value loaded at reset; SHALL be nonzero.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 compute_colors_en  input  1  level enable from the game state machine; high while colours are to be computed.
REQ-005 card_idx  input  4  read address of card 0..15 (4x4 board).
REQ-006 compute_done  output  1  one-cycle pulse when the shuffled board is complete.
REQ-007 card_color  output  3  colour index 0..7 of card card_idx, registered.
REQ-008 colors_valid  output  1  level; high while the array holds a completed shuffle.

Function
REQ-009 Board SHALL be held as 16 entries x 3 bits; each colour 0..7 SHALL appear exactly twice after a completed shuffle.
REQ-010 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle out of reset, independent of state, so the result depends on when the player starts.
REQ-011 States SHALL be IDLE, INIT, SHUFFLE, DONE, HOLD.
REQ-012 IDLE: when compute_colors_en=1, go to INIT with fill index 0, clear colors_valid.
REQ-013 INIT: write entry[k] = k>>1 for k=0..15, one entry per cycle (16 cycles), then go to SHUFFLE with i=15.
REQ-014 SHUFFLE (Fisher-Yates, downward): j = LFSR[3:0]; if j<=i swap entry[i] and entry[j] in the same cycle, and decrement i; otherwise reject, hold i, retry the next cycle.
REQ-015 A swap with j==i SHALL leave the array unchanged and still count as a step.
REQ-016 After the step with i=1, go to DONE; total latency = 16 + 15 + number of rejections cycles from INIT entry.
REQ-017 DONE: assert compute_done for exactly one cycle, set colors_valid=1, go to HOLD.
REQ-018 HOLD: stay while compute_colors_en=1, with no further compute_done pulses; on compute_colors_en=0 go to IDLE, keeping colors_valid=1 and the array contents.
REQ-019 compute_colors_en=0 in INIT or SHUFFLE SHALL abort to IDLE next cycle, with no compute_done and colors_valid=0.
REQ-020 card_color SHALL equal entry[card_idx] sampled one cycle earlier, in every state; the value is meaningful only when colors_valid=1.
REQ-021 compute_colors_en held high continuously SHALL produce exactly one shuffle; re-shuffling requires a low level, then high.

Reset
REQ-022 rst SHALL set state=IDLE, LFSR=LFSR_SEED, compute_done=0, colors_valid=0, card_color=0, all entries=0, and indices=0.
REQ-023 rst SHALL take priority over compute_colors_en in every state, including mid-INIT and mid-SHUFFLE.

Structure
REQ-024 A shared game package SHALL hold NUM_CARDS=16, CARD_IDX_W=4, COLOR_W=3, and the state encodings.
REQ-025 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst, seed, and q.
REQ-026 The array SHALL be registers, not block RAM, because a swap needs dual read and write in one cycle.

Verification
REQ-027 Reset: assert rst for 2 cycles -> compute_done=0, colors_valid=0, card_color=0; LFSR is 16'hACE1 on the first cycle after reset.
REQ-028 Full shuffle: raise en at cycle 10 and hold -> exactly one compute_done pulse after at least 31 cycles; a read of all 16 indices gives each value 0..7 exactly twice, with colors_valid=1.
REQ-029 Re-arm: keep en high for 100 cycles after done -> no second pulse; drop en 1 cycle, then raise -> a new pulse; with a different start cycle, the colour permutation differs.
REQ-030 Abort: drop en 5 cycles into SHUFFLE -> IDLE, colors_valid=0, no pulse; then raise en -> a normal completion.
REQ-031 Read latency: set card_idx=5 at cycle n, with entry[5]=3 -> card_color=3 at cycle n+1.
REQ-032 Reset mid-SHUFFLE: rst for 1 cycle -> all outputs 0, state IDLE, no compute_done pulse.
